// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional same-cycle update-to-lookup bypass: define BTB_BYPASS_EN.
module branch_target_buffer #(
    parameter int         ENTRIES    = 16,
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] CTR_INIT   = 2'b01
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] PCF,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predicted_pc,
    output logic                  btb_hit,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic                  update_taken,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  update_mispredict,
    input  logic                  bp_flush,
    output logic [15:0]           mispredict_count
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS - 2;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(3'd4);

    function automatic logic [1:0] ctr_inc(input logic [1:0] ctr);
        if (ctr == 2'b11) begin
            return 2'b11;
        end else begin
            return ctr + 2'b01;
        end
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] ctr);
        if (ctr == 2'b00) begin
            return 2'b00;
        end else begin
            return ctr - 2'b01;
        end
    endfunction

    logic                  valid_r  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_r    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_r [ENTRIES];
    logic [1:0]            ctr_r    [ENTRIES];
    logic [15:0]           mis_cnt_r;

    logic [IDX_BITS-1:0]   lk_idx_s;
    logic [TAG_BITS-1:0]   lk_tag_s;
    logic [IDX_BITS-1:0]   upd_idx_s;
    logic [TAG_BITS-1:0]   upd_tag_s;
    logic                  upd_hit_s;
    logic                  upd_we_s;
    logic [1:0]            new_ctr_s;
    logic [ADDR_WIDTH-1:0] new_target_s;
    logic                  rd_valid_s;
    logic                  rd_tag_match_s;
    logic [1:0]            rd_ctr_s;
    logic [ADDR_WIDTH-1:0] rd_target_s;
    logic                  hit_s;
    logic                  taken_s;
    logic                  unused_pc_lsb_s;

    // Word-aligned PCs: the two low bits carry no information.
    assign unused_pc_lsb_s = ^{PCF[1:0], update_pc[1:0]};

    assign lk_idx_s  = PCF[IDX_BITS+1:2];
    assign lk_tag_s  = PCF[ADDR_WIDTH-1:IDX_BITS+2];
    assign upd_idx_s = update_pc[IDX_BITS+1:2];
    assign upd_tag_s = update_pc[ADDR_WIDTH-1:IDX_BITS+2];

    assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    // A miss that resolved not-taken leaves the table untouched.
    assign upd_we_s  = update_valid && (upd_hit_s || update_taken);

    // Post-update contents of the entry addressed by update_pc.
    always_comb begin
        new_ctr_s    = ctr_r[upd_idx_s];
        new_target_s = target_r[upd_idx_s];
        if (upd_hit_s) begin
            if (update_taken) begin
                new_ctr_s    = ctr_inc(ctr_r[upd_idx_s]);
                new_target_s = update_target;
            end else begin
                new_ctr_s    = ctr_dec(ctr_r[upd_idx_s]);
            end
        end else begin
            new_ctr_s    = 2'b10;
            new_target_s = update_target;
        end
    end

    // Lookup read port, optionally forwarding a same-cycle update.
    always_comb begin
        rd_valid_s     = valid_r[lk_idx_s];
        rd_tag_match_s = (tag_r[lk_idx_s] == lk_tag_s);
        rd_ctr_s       = ctr_r[lk_idx_s];
        rd_target_s    = target_r[lk_idx_s];
`ifdef BTB_BYPASS_EN
        if (upd_we_s && !bp_flush && !reset &&
            (upd_idx_s == lk_idx_s) && (upd_tag_s == lk_tag_s)) begin
            rd_valid_s     = 1'b1;
            rd_tag_match_s = 1'b1;
            rd_ctr_s       = new_ctr_s;
            rd_target_s    = new_target_s;
        end else begin
            rd_valid_s     = valid_r[lk_idx_s];
            rd_tag_match_s = (tag_r[lk_idx_s] == lk_tag_s);
            rd_ctr_s       = ctr_r[lk_idx_s];
            rd_target_s    = target_r[lk_idx_s];
        end
`endif
    end

    // Prediction outputs; a reset cycle never reports a hit.
    always_comb begin
        hit_s   = !reset && rd_valid_s && rd_tag_match_s;
        taken_s = hit_s && rd_ctr_s[1];
        if (taken_s) begin
            predicted_pc = rd_target_s;
        end else begin
            predicted_pc = PCF + PC_STEP;
        end
    end

    assign btb_hit       = hit_s;
    assign predict_taken = taken_s;

    // Table state: reset beats flush, flush beats training.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                ctr_r[i]    <= CTR_INIT;
                tag_r[i]    <= '0;
                target_r[i] <= '0;
            end
        end else if (bp_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
                ctr_r[i]   <= CTR_INIT;
            end
        end else if (upd_we_s) begin
            valid_r[upd_idx_s]  <= 1'b1;
            tag_r[upd_idx_s]    <= upd_tag_s;
            target_r[upd_idx_s] <= new_target_s;
            ctr_r[upd_idx_s]    <= new_ctr_s;
        end
    end

    // Saturating mispredict counter, preserved across flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            mis_cnt_r <= 16'h0000;
        end else if (update_valid && update_mispredict && (mis_cnt_r != 16'hFFFF)) begin
            mis_cnt_r <= mis_cnt_r + 16'h0001;
        end else begin
            mis_cnt_r <= mis_cnt_r;
        end
    end

    assign mispredict_count = reset ? 16'h0000 : mis_cnt_r;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed vectors push expected
// lookup results; a negedge monitor pops and compares them.
module tb_branch_target_buffer;

    logic        clk;
    logic        reset;
    logic [31:0] PCF;
    logic        predict_taken;
    logic [31:0] predicted_pc;
    logic        btb_hit;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispredict;
    logic        bp_flush;
    logic [15:0] mispredict_count;

    branch_target_buffer #(
        .ENTRIES    (16),
        .ADDR_WIDTH (32),
        .CTR_INIT   (2'b01)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .PCF               (PCF),
        .predict_taken     (predict_taken),
        .predicted_pc      (predicted_pc),
        .btb_hit           (btb_hit),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .bp_flush          (bp_flush),
        .mispredict_count  (mispredict_count)
    );

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] pc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_mis     = 16'h0000;
    logic        pend_rst    = 1'b1;
    logic        pend_inc    = 1'b0;
    logic        cur_rs      = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the oldest expectation against the live outputs.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            vectors++;
            if (btb_hit !== e.hit || predict_taken !== e.taken ||
                predicted_pc !== e.pc || mispredict_count !== e.cnt) begin
                miscompares++;
                $display("FAIL %s: got hit=%0b taken=%0b pc=%h cnt=%h, expected hit=%0b taken=%0b pc=%h cnt=%h",
                         e.name, btb_hit, predict_taken, predicted_pc, mispredict_count,
                         e.hit, e.taken, e.pc, e.cnt);
            end
        end
    end

    task automatic apply(input logic [31:0] pcf, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt, input logic um,
                         input logic fl, input logic rs);
        @(posedge clk);
        #1;
        if (pend_rst) exp_mis = 16'h0000;
        else if (pend_inc && exp_mis != 16'hFFFF) exp_mis = exp_mis + 16'h0001;
        PCF               = pcf;
        update_valid      = uv;
        update_pc         = upc;
        update_taken      = ut;
        update_target     = utgt;
        update_mispredict = um;
        bp_flush          = fl;
        reset             = rs;
        pend_rst          = rs;
        pend_inc          = uv && um;
        cur_rs            = rs;
    endtask

    task automatic idle(input logic [31:0] pcf);
        apply(pcf, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pcf, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic um);
        apply(pcf, 1'b1, upc, ut, utgt, um, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string nm, input logic h, input logic t, input logic [31:0] pc);
        exp_t e;
        e.name  = nm;
        e.hit   = h;
        e.taken = t;
        e.pc    = pc;
        e.cnt   = cur_rs ? 16'h0000 : exp_mis;
        sb_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; PCF = 32'h100; update_valid = 1'b0; update_pc = 32'h0;
        update_taken = 1'b0; update_target = 32'h0; update_mispredict = 1'b0; bp_flush = 1'b0;

        apply(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        expect_out("reset_hold", 1'b0, 1'b0, 32'h104);
        idle(32'h100);
        expect_out("reset_state", 1'b0, 1'b0, 32'h104);

        upd(32'h100, 32'h100, 1'b1, 32'h200, 1'b1);
`ifdef BTB_BYPASS_EN
        expect_out("alloc_same_cycle", 1'b1, 1'b1, 32'h200);
`else
        expect_out("alloc_same_cycle", 1'b0, 1'b0, 32'h104);
`endif
        idle(32'h100);
        expect_out("alloc", 1'b1, 1'b1, 32'h200);

        upd(32'h104, 32'h100, 1'b1, 32'h200, 1'b0);
        expect_out("other_idx_miss", 1'b0, 1'b0, 32'h108);
        idle(32'h100);
        expect_out("ctr3_a", 1'b1, 1'b1, 32'h200);
        upd(32'h104, 32'h100, 1'b1, 32'h200, 1'b0);
        idle(32'h100);
        expect_out("ctr3_b", 1'b1, 1'b1, 32'h200);
        upd(32'h104, 32'h100, 1'b1, 32'h240, 1'b0);
        idle(32'h100);
        expect_out("tgt_update", 1'b1, 1'b1, 32'h240);

        upd(32'h104, 32'h100, 1'b0, 32'h999, 1'b1);
        idle(32'h100);
        expect_out("nt_ctr2_tgt_kept", 1'b1, 1'b1, 32'h240);
        upd(32'h104, 32'h100, 1'b0, 32'h0, 1'b1);
        idle(32'h100);
        expect_out("nt_ctr1", 1'b1, 1'b0, 32'h104);

        apply(32'h104, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        upd(32'h104, 32'h100, 1'b0, 32'h0, 1'b0);
        expect_out("mis_ignored_no_valid", 1'b0, 1'b0, 32'h108);
        upd(32'h104, 32'h100, 1'b0, 32'h0, 1'b0);
        upd(32'h104, 32'h100, 1'b1, 32'h280, 1'b0);
        idle(32'h100);
        expect_out("ctr_floor", 1'b1, 1'b0, 32'h104);
        upd(32'h104, 32'h100, 1'b1, 32'h280, 1'b0);
        idle(32'h100);
        expect_out("ctr_recover", 1'b1, 1'b1, 32'h280);

        upd(32'h104, 32'h140, 1'b1, 32'h500, 1'b0);
        idle(32'h100);
        expect_out("alias_evict", 1'b0, 1'b0, 32'h104);
        idle(32'h140);
        expect_out("alias_hit", 1'b1, 1'b1, 32'h500);
        upd(32'h104, 32'h180, 1'b0, 32'h0, 1'b0);
        idle(32'h140);
        expect_out("miss_nt_keep", 1'b1, 1'b1, 32'h500);
        idle(32'h180);
        expect_out("miss_nt_noalloc", 1'b0, 1'b0, 32'h184);

        apply(32'h100, 1'b1, 32'h100, 1'b1, 32'h600, 1'b0, 1'b1, 1'b0);
        expect_out("flush_cycle", 1'b0, 1'b0, 32'h104);
        idle(32'h100);
        expect_out("flush_drop", 1'b0, 1'b0, 32'h104);
        idle(32'h140);
        expect_out("flush_clear_cnt_kept", 1'b0, 1'b0, 32'h144);

        upd(32'h300, 32'h300, 1'b1, 32'h400, 1'b0);
`ifdef BTB_BYPASS_EN
        expect_out("bypass_cycle", 1'b1, 1'b1, 32'h400);
`else
        expect_out("bypass_cycle", 1'b0, 1'b0, 32'h304);
`endif
        idle(32'h300);
        expect_out("bypass_next", 1'b1, 1'b1, 32'h400);
        idle(32'hFFFF_FFFC);
        expect_out("pc_wrap", 1'b0, 1'b0, 32'h0000_0000);

        for (int i = 0; i < 70000; i++) begin
            upd(32'h104, 32'h10C, 1'b0, 32'h0, 1'b1);
        end
        idle(32'h10C);
        expect_out("cnt_saturate", 1'b0, 1'b0, 32'h110);
        idle(32'h300);
        expect_out("entry_survives_sat", 1'b1, 1'b1, 32'h400);

        apply(32'h300, 1'b1, 32'h300, 1'b1, 32'h700, 1'b1, 1'b0, 1'b1);
        expect_out("reset_cycle", 1'b0, 1'b0, 32'h304);
        idle(32'h300);
        expect_out("post_reset", 1'b0, 1'b0, 32'h304);
        upd(32'h104, 32'h300, 1'b1, 32'h440, 1'b0);
        idle(32'h300);
        expect_out("realloc", 1'b1, 1'b1, 32'h440);

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
